s8sp_seq_ctrl: RTL and testbench



---
 rtl/s8sp_seq_ctrl_pkg.sv | 43 ++++
 rtl/s8sp_seq_ctrl_if.sv | 28 ++
 rtl/s8sp_mem_wait.sv | 42 ++++
 rtl/s8sp_seq_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_s8sp_seq_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/s8sp_seq_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// s8sp_pkg
// Shared definitions for the S8SP sequencer: opcode constants, the
// sequencer state encoding, default register indices and a small helper
// that recognises the instructions that touch memory.
// ----------------------------------------------------------------------------
package s8sp_pkg;

  // Opcode map (upper four bits of the instruction register)
  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_JMP  = 4'd1;
  localparam logic [3:0] OP_RDM  = 4'd2;
  localparam logic [3:0] OP_WRM  = 4'd3;
  localparam logic [3:0] OP_CPR  = 4'd4;
  localparam logic [3:0] OP_ADD  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_LLS  = 4'd7;
  localparam logic [3:0] OP_LMS  = 4'd8;
  localparam logic [3:0] OP_CFR  = 4'd9;
  localparam logic [3:0] OP_JMPC = 4'd10;
  localparam logic [3:0] OP_HLT  = 4'd15;

  // Default register-file positions of the architectural registers
  localparam int AR_IDX_DEF = 0;
  localparam int DR_IDX_DEF = 1;
  localparam int GR_IDX_DEF = 2;
  localparam int PR_IDX_DEF = 3;

  typedef enum logic [2:0] {
    ST_RST,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEM_WAIT,
    ST_HALT
  } state_t;

  // Instructions that stall EXECUTE until memory answers
  function automatic logic isMemOp(input logic [3:0] op);
    return (op == OP_RDM) || (op == OP_WRM);
  endfunction

endpackage

// File: rtl/s8sp_seq_ctrl_if.sv
// ----------------------------------------------------------------------------
// s8sp_seq_ctrl_if
// Memory-side bus of the S8SP sequencer.
//   rd_mem / wr_mem     : read / write strobes (sequencer -> memory)
//   ctrl_pr_on_addr     : program register drives the address bus
//   ctrl_ar_on_addr     : address register drives the address bus
//   mem_ready           : memory finishes the pending access this cycle
// master = sequencer side, slave = memory side.
// ----------------------------------------------------------------------------
interface s8sp_seq_ctrl_if;

  logic rd_mem;
  logic wr_mem;
  logic ctrl_pr_on_addr;
  logic ctrl_ar_on_addr;
  logic mem_ready;

  modport master (
    output rd_mem, wr_mem, ctrl_pr_on_addr, ctrl_ar_on_addr,
    input  mem_ready
  );

  modport slave (
    input  rd_mem, wr_mem, ctrl_pr_on_addr, ctrl_ar_on_addr,
    output mem_ready
  );

endinterface

// File: rtl/s8sp_mem_wait.sv
// ----------------------------------------------------------------------------
// s8sp_mem_wait
// Counts the cycles a memory access has been outstanding and flags a
// timeout in the last permitted cycle when memory still has not answered.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   i_active     : a memory access is being presented this cycle
//   i_memReady   : memory completes the access this cycle
//   o_timeout    : last permitted cycle passed without i_memReady
// ----------------------------------------------------------------------------
module s8sp_mem_wait
  import s8sp_pkg::*;
#(
  parameter int MEM_TMO = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic i_active,
  input  logic i_memReady,
  output logic o_timeout
);

  logic [7:0] r_waitCnt;
  logic       w_lastCycle;

  // A ready in the last cycle still wins; only a silent last cycle times out
  assign w_lastCycle = (r_waitCnt == 8'(MEM_TMO - 1));
  assign o_timeout   = i_active && !i_memReady && w_lastCycle;

  // Counter returns to zero whenever no access is pending, so every new
  // access starts from a clean count
  always_ff @(posedge clk) begin
    if (reset) begin
      r_waitCnt <= '0;
    end else if (i_active && !i_memReady && !w_lastCycle) begin
      r_waitCnt <= r_waitCnt + 8'd1;
    end else begin
      r_waitCnt <= '0;
    end
  end

endmodule

// File: rtl/s8sp_seq_ctrl.sv
// ----------------------------------------------------------------------------
// s8sp_seq_ctrl
// Fetch/decode/execute sequencer of the S8SP CPU. All control outputs are
// decoded combinationally from the state, the instruction register, the
// memory handshake and the ALU flags.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   ctrl_ir_code         : instruction {opcode, field A, field B}
//   flag_z, flag_c       : ALU zero / carry flags
//   memBus (master)      : memory strobes, address select, mem_ready
//   ctrl_load/ctrl_drv   : one-hot register load / drive
//   ctrl_load_*_gr       : GR half loads
//   ctrl_* scalars       : datapath steering
//   ctrl_add_oprnd*_sel  : ALU operand selects
//   halted, illegal_op, bus_err : status (illegal_op, bus_err pulse)
// Build option: S8SP_COND_JMP_EN enables the conditional jump JMPC;
// without it opcode 10 is treated as illegal.
// ----------------------------------------------------------------------------
module s8sp_seq_ctrl
  import s8sp_pkg::*;
#(
  parameter int REG_SEL_W = 2,
  parameter int MEM_TMO   = 15,
  parameter int AR_IDX    = AR_IDX_DEF,
  parameter int DR_IDX    = DR_IDX_DEF,
  parameter int GR_IDX    = GR_IDX_DEF,
  parameter int PR_IDX    = PR_IDX_DEF,
  localparam int NREG     = 2**REG_SEL_W,
  localparam int IR_W     = 4 + 2*REG_SEL_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IR_W-1:0]      ctrl_ir_code,
  input  logic                 flag_z,
  input  logic                 flag_c,
  s8sp_seq_ctrl_if.master      memBus,
  output logic [NREG-1:0]      ctrl_load,
  output logic                 ctrl_load_lsb_gr,
  output logic                 ctrl_load_msb_gr,
  output logic [NREG-1:0]      ctrl_drv,
  output logic                 ctrl_load_ir,
  output logic                 ctrl_inc_pr,
  output logic                 ctrl_ir_2_data,
  output logic                 ctrl_alu_2_data,
  output logic                 ctrl_flag_2_data,
  output logic                 ctrl_sub_nadd,
  output logic [REG_SEL_W-1:0] ctrl_add_oprnd1_sel,
  output logic [REG_SEL_W-1:0] ctrl_add_oprnd2_sel,
  output logic                 halted,
  output logic                 illegal_op,
  output logic                 bus_err
);

  localparam logic [NREG-1:0] ONE_HOT0 = {{(NREG-1){1'b0}}, 1'b1};

  state_t                 r_state;
  state_t                 w_nextState;
  logic [3:0]             w_opcode;
  logic [REG_SEL_W-1:0]   w_fieldA;
  logic [REG_SEL_W-1:0]   w_fieldB;
  logic                   w_isMemOp;
  logic                   w_memActive;
  logic                   w_timeout;

  assign w_opcode  = ctrl_ir_code[IR_W-1 -: 4];
  assign w_fieldA  = ctrl_ir_code[2*REG_SEL_W-1 -: REG_SEL_W];
  assign w_fieldB  = ctrl_ir_code[REG_SEL_W-1:0];
  assign w_isMemOp = isMemOp(w_opcode);

  // Kept outside the decode block so the timeout path has no false loop
  assign w_memActive = (r_state == ST_FETCH) ||
                       (((r_state == ST_EXECUTE) || (r_state == ST_MEM_WAIT)) && w_isMemOp);

`ifndef S8SP_COND_JMP_EN
  logic w_unusedFlags;
  assign w_unusedFlags = flag_z ^ flag_c;
`endif

  s8sp_mem_wait #(
    .MEM_TMO(MEM_TMO)
  ) u_memWait (
    .clk       (clk),
    .reset     (reset),
    .i_active  (w_memActive),
    .i_memReady(memBus.mem_ready),
    .o_timeout (w_timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RST;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state and every control output; a timeout suppresses all strobes
  // of the failing access and only reports bus_err
  always_comb begin
    w_nextState             = r_state;
    memBus.rd_mem           = 1'b0;
    memBus.wr_mem           = 1'b0;
    memBus.ctrl_pr_on_addr  = 1'b0;
    memBus.ctrl_ar_on_addr  = 1'b0;
    ctrl_load               = '0;
    ctrl_load_lsb_gr        = 1'b0;
    ctrl_load_msb_gr        = 1'b0;
    ctrl_drv                = '0;
    ctrl_load_ir            = 1'b0;
    ctrl_inc_pr             = 1'b0;
    ctrl_ir_2_data          = 1'b0;
    ctrl_alu_2_data         = 1'b0;
    ctrl_flag_2_data        = 1'b0;
    ctrl_sub_nadd           = 1'b0;
    ctrl_add_oprnd1_sel     = REG_SEL_W'(DR_IDX);
    ctrl_add_oprnd2_sel     = REG_SEL_W'(GR_IDX);
    halted                  = 1'b0;
    illegal_op              = 1'b0;
    bus_err                 = 1'b0;

    case (r_state)
      ST_RST: w_nextState = ST_FETCH;

      ST_FETCH: begin
        if (w_timeout) begin
          bus_err     = 1'b1;
          w_nextState = ST_RST;
        end else begin
          memBus.rd_mem          = 1'b1;
          memBus.ctrl_pr_on_addr = 1'b1;
          ctrl_load_ir           = 1'b1;
          if (memBus.mem_ready) begin
            ctrl_inc_pr = 1'b1;
            w_nextState = ST_DECODE;
          end
        end
      end

      ST_DECODE: w_nextState = ST_EXECUTE;

      ST_EXECUTE, ST_MEM_WAIT: begin
        w_nextState = ST_FETCH;
        if (w_isMemOp) begin
          if (w_timeout) begin
            bus_err     = 1'b1;
            w_nextState = ST_RST;
          end else begin
            memBus.ctrl_ar_on_addr = 1'b1;
            if (w_opcode == OP_RDM) begin
              memBus.rd_mem = 1'b1;
              if (memBus.mem_ready) begin
                ctrl_load = ONE_HOT0 << w_fieldA;
              end
            end else begin
              memBus.wr_mem = 1'b1;
              ctrl_drv      = ONE_HOT0 << w_fieldA;
            end
            if (!memBus.mem_ready) begin
              w_nextState = ST_MEM_WAIT;
            end
          end
        end else if (r_state == ST_EXECUTE) begin
          case (w_opcode)
            OP_NOP: begin end
            OP_JMP: begin
              ctrl_drv  = ONE_HOT0 << AR_IDX;
              ctrl_load = ONE_HOT0 << PR_IDX;
            end
            OP_CPR: begin
              if (w_fieldA != w_fieldB) begin
                ctrl_drv  = ONE_HOT0 << w_fieldB;
                ctrl_load = ONE_HOT0 << w_fieldA;
              end
            end
            OP_ADD, OP_SUB: begin
              ctrl_add_oprnd1_sel = w_fieldA;
              ctrl_add_oprnd2_sel = w_fieldB;
              ctrl_alu_2_data     = 1'b1;
              ctrl_load           = ONE_HOT0 << w_fieldA;
              ctrl_sub_nadd       = (w_opcode == OP_SUB);
            end
            OP_LLS: begin
              ctrl_ir_2_data   = 1'b1;
              ctrl_load_lsb_gr = 1'b1;
            end
            OP_LMS: begin
              ctrl_ir_2_data   = 1'b1;
              ctrl_load_msb_gr = 1'b1;
            end
            OP_CFR: begin
              ctrl_flag_2_data = 1'b1;
              ctrl_load_lsb_gr = 1'b1;
            end
`ifdef S8SP_COND_JMP_EN
            OP_JMPC: begin
              if (w_fieldB[0] ? flag_c : flag_z) begin
                ctrl_drv  = ONE_HOT0 << AR_IDX;
                ctrl_load = ONE_HOT0 << PR_IDX;
              end
            end
`endif
            OP_HLT: w_nextState = ST_HALT;
            default: illegal_op = 1'b1;
          endcase
        end
      end

      ST_HALT: begin
        halted      = 1'b1;
        w_nextState = ST_HALT;
      end

      default: w_nextState = ST_RST;
    endcase
  end

endmodule

// File: tb/tb_s8sp_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_s8sp_seq_ctrl
// Directed scoreboard bench for s8sp_seq_ctrl. Each stimulus cycle pushes
// the hand-computed output vector for that cycle; a monitor pops and
// compares it on the falling edge. A second instance with REG_SEL_W=3
// exercises the wide one-hot decode. JMPC expectations follow
// S8SP_COND_JMP_EN.
// ----------------------------------------------------------------------------
module tb_s8sp_seq_ctrl;
  import s8sp_pkg::*;

  typedef struct packed {
    logic       rdMem;
    logic       wrMem;
    logic       prOnAddr;
    logic       arOnAddr;
    logic [3:0] load;
    logic       lsbGr;
    logic       msbGr;
    logic [3:0] drv;
    logic       loadIr;
    logic       incPr;
    logic       ir2Data;
    logic       alu2Data;
    logic       flag2Data;
    logic       subNadd;
    logic [1:0] op1;
    logic [1:0] op2;
    logic       halted;
    logic       illegalOp;
    logic       busErr;
  } obs_t;

  typedef struct {
    string name;
    obs_t  exp;
  } item_t;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } item3_t;

  logic       clk = 1'b0;
  logic       rstIn = 1'b1;
  logic [7:0] irCode = 8'h00;
  logic       memRdy = 1'b0;
  logic       flagZ = 1'b0;
  logic       flagC = 1'b0;

  logic [3:0] load, drv;
  logic [1:0] op1, op2;
  logic       lsbGr, msbGr, loadIr, incPr, ir2Data, alu2Data, flag2Data, subNadd;
  logic       halted, illegalOp, busErr;
  obs_t       obs;

  logic       rst3 = 1'b1;
  logic [9:0] ir3 = 10'h12E;
  logic [7:0] load3, drv3;
  logic [14:0] unused3;
  logic       done3 = 1'b0;

  int         nChecks = 0;
  int         nFails = 0;
  item_t      scoreQ[$];
  item3_t     scoreQ3[$];
  item_t      curItem;
  item3_t     curItem3;

  always #5 clk = ~clk;

  s8sp_seq_ctrl_if memIf();
  s8sp_seq_ctrl_if memIf3();
  assign memIf.mem_ready  = memRdy;
  assign memIf3.mem_ready = 1'b1;

  s8sp_seq_ctrl dut (
    .clk                (clk),
    .reset              (rstIn),
    .ctrl_ir_code       (irCode),
    .flag_z             (flagZ),
    .flag_c             (flagC),
    .memBus             (memIf),
    .ctrl_load          (load),
    .ctrl_load_lsb_gr   (lsbGr),
    .ctrl_load_msb_gr   (msbGr),
    .ctrl_drv           (drv),
    .ctrl_load_ir       (loadIr),
    .ctrl_inc_pr        (incPr),
    .ctrl_ir_2_data     (ir2Data),
    .ctrl_alu_2_data    (alu2Data),
    .ctrl_flag_2_data   (flag2Data),
    .ctrl_sub_nadd      (subNadd),
    .ctrl_add_oprnd1_sel(op1),
    .ctrl_add_oprnd2_sel(op2),
    .halted             (halted),
    .illegal_op         (illegalOp),
    .bus_err            (busErr)
  );

  s8sp_seq_ctrl #(.REG_SEL_W(3)) dut3 (
    .clk                (clk),
    .reset              (rst3),
    .ctrl_ir_code       (ir3),
    .flag_z             (1'b0),
    .flag_c             (1'b0),
    .memBus             (memIf3),
    .ctrl_load          (load3),
    .ctrl_load_lsb_gr   (unused3[0]),
    .ctrl_load_msb_gr   (unused3[1]),
    .ctrl_drv           (drv3),
    .ctrl_load_ir       (unused3[2]),
    .ctrl_inc_pr        (unused3[3]),
    .ctrl_ir_2_data     (unused3[4]),
    .ctrl_alu_2_data    (unused3[5]),
    .ctrl_flag_2_data   (unused3[6]),
    .ctrl_sub_nadd      (unused3[7]),
    .ctrl_add_oprnd1_sel(unused3[10:8]),
    .ctrl_add_oprnd2_sel(unused3[13:11]),
    .halted             (unused3[14]),
    .illegal_op         (),
    .bus_err            ()
  );

  assign obs = {memIf.rd_mem, memIf.wr_mem, memIf.ctrl_pr_on_addr, memIf.ctrl_ar_on_addr,
                load, lsbGr, msbGr, drv, loadIr, incPr, ir2Data, alu2Data, flag2Data,
                subNadd, op1, op2, halted, illegalOp, busErr};

  // Monitor: one expected vector per stimulus cycle, compared mid-cycle
  always @(negedge clk) begin
    if (scoreQ.size() > 0) begin
      curItem = scoreQ.pop_front();
      nChecks++;
      if (obs !== curItem.exp) begin
        nFails++;
        $display("[TB] FAIL %s: got %h expected %h", curItem.name, obs, curItem.exp);
      end
    end
    if (scoreQ3.size() > 0) begin
      curItem3 = scoreQ3.pop_front();
      nChecks++;
      if ({drv3, load3} !== curItem3.exp) begin
        nFails++;
        $display("[TB] FAIL %s: got drv/load %h expected %h", curItem3.name, {drv3, load3}, curItem3.exp);
      end
    end
  end

  function automatic obs_t idleE();
    obs_t e;
    e     = '0;
    e.op1 = 2'd1;
    e.op2 = 2'd2;
    return e;
  endfunction

  function automatic obs_t fetchE(input logic rdy);
    obs_t e;
    e          = idleE();
    e.rdMem    = 1'b1;
    e.prOnAddr = 1'b1;
    e.loadIr   = 1'b1;
    e.incPr    = rdy;
    return e;
  endfunction

  task automatic applyStimulus(input string name, input logic [7:0] ir, input logic rdy,
                               input logic fz, input logic fc, input logic rst, input obs_t exp);
    item_t it;
    @(posedge clk);
    #1;
    irCode = ir;
    memRdy = rdy;
    flagZ  = fz;
    flagC  = fc;
    rstIn  = rst;
    it.name = name;
    it.exp  = exp;
    scoreQ.push_back(it);
  endtask

  task automatic runInstr(input string name, input logic [7:0] ir, input logic fz,
                          input logic fc, input obs_t execExp);
    applyStimulus({name, "_fetch"},  ir, 1'b1, fz, fc, 1'b0, fetchE(1'b1));
    applyStimulus({name, "_decode"}, ir, 1'b1, fz, fc, 1'b0, idleE());
    applyStimulus({name, "_exec"},   ir, 1'b1, fz, fc, 1'b0, execExp);
  endtask

  // Wide-decode instance: reset, fetch, decode, then CPR 5<-6
  initial begin
    item3_t it;
    @(posedge clk); #1;
    it.name = "w3_rst"; it.exp = 16'h0000; scoreQ3.push_back(it);
    rst3 = 1'b0;
    @(posedge clk); #1;
    it.name = "w3_fetch"; it.exp = 16'h0000; scoreQ3.push_back(it);
    @(posedge clk); #1;
    it.name = "w3_decode"; it.exp = 16'h0000; scoreQ3.push_back(it);
    @(posedge clk); #1;
    it.name = "w3_cpr"; it.exp = {8'h40, 8'h20}; scoreQ3.push_back(it);
    @(posedge clk); #1;
    rst3  = 1'b1;
    done3 = 1'b1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    obs_t e;
    applyStimulus("rst0", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, idleE());
    applyStimulus("rst1", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, idleE());

    runInstr("nop0", 8'h00, 1'b0, 1'b0, idleE());
    runInstr("nop1", 8'h00, 1'b0, 1'b0, idleE());

    e = idleE(); e.drv = 4'b0001; e.load = 4'b1000;
    runInstr("jmp", 8'h10, 1'b0, 1'b0, e);

    // RDM into DR with three slow cycles
    applyStimulus("rdm_fetch",  8'h24, 1'b1, 1'b0, 1'b0, 1'b0, fetchE(1'b1));
    applyStimulus("rdm_decode", 8'h24, 1'b1, 1'b0, 1'b0, 1'b0, idleE());
    e = idleE(); e.rdMem = 1'b1; e.arOnAddr = 1'b1;
    applyStimulus("rdm_wait0", 8'h24, 1'b0, 1'b0, 1'b0, 1'b0, e);
    applyStimulus("rdm_wait1", 8'h24, 1'b0, 1'b0, 1'b0, 1'b0, e);
    applyStimulus("rdm_wait2", 8'h24, 1'b0, 1'b0, 1'b0, 1'b0, e);
    e.load = 4'b0010;
    applyStimulus("rdm_done", 8'h24, 1'b1, 1'b0, 1'b0, 1'b0, e);

    e = idleE(); e.wrMem = 1'b1; e.arOnAddr = 1'b1; e.drv = 4'b0100;
    runInstr("wrm", 8'h38, 1'b0, 1'b0, e);

    e = idleE(); e.drv = 4'b0010; e.load = 4'b0001;
    runInstr("cpr", 8'h41, 1'b0, 1'b0, e);
    runInstr("cpr_same", 8'h45, 1'b0, 1'b0, idleE());

    e = idleE(); e.op1 = 2'd1; e.op2 = 2'd3; e.alu2Data = 1'b1; e.load = 4'b0010;
    runInstr("add", 8'h57, 1'b0, 1'b0, e);
    e = idleE(); e.op1 = 2'd2; e.op2 = 2'd0; e.alu2Data = 1'b1; e.load = 4'b0100; e.subNadd = 1'b1;
    runInstr("sub", 8'h68, 1'b0, 1'b0, e);

    e = idleE(); e.ir2Data = 1'b1; e.lsbGr = 1'b1;
    runInstr("lls", 8'h70, 1'b0, 1'b0, e);
    e = idleE(); e.ir2Data = 1'b1; e.msbGr = 1'b1;
    runInstr("lms", 8'h80, 1'b0, 1'b0, e);
    e = idleE(); e.flag2Data = 1'b1; e.lsbGr = 1'b1;
    runInstr("cfr", 8'h90, 1'b0, 1'b0, e);

    e = idleE(); e.illegalOp = 1'b1;
    runInstr("illegal12", 8'hC0, 1'b0, 1'b0, e);

`ifdef S8SP_COND_JMP_EN
    e = idleE(); e.drv = 4'b0001; e.load = 4'b1000;
    runInstr("jmpc_z1", 8'hA0, 1'b1, 1'b0, e);
    runInstr("jmpc_z0", 8'hA0, 1'b0, 1'b1, idleE());
    runInstr("jmpc_c1", 8'hA1, 1'b0, 1'b1, e);
`else
    e = idleE(); e.illegalOp = 1'b1;
    runInstr("jmpc_z1", 8'hA0, 1'b1, 1'b0, e);
    runInstr("jmpc_z0", 8'hA0, 1'b0, 1'b1, e);
    runInstr("jmpc_c1", 8'hA1, 1'b0, 1'b1, e);
`endif

    // Fetch timeout: 14 silent cycles, then bus_err in the 15th
    for (int i = 0; i < 14; i++) begin
      applyStimulus("tmo_wait", 8'h10, 1'b0, 1'b0, 1'b0, 1'b0, fetchE(1'b0));
    end
    e = idleE(); e.busErr = 1'b1;
    applyStimulus("tmo_buserr", 8'h10, 1'b0, 1'b0, 1'b0, 1'b0, e);
    applyStimulus("tmo_rst", 8'h10, 1'b1, 1'b0, 1'b0, 1'b0, idleE());
    applyStimulus("tmo_refetch", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, fetchE(1'b1));
    applyStimulus("tmo_decode", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, idleE());
    applyStimulus("tmo_exec", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, idleE());

    // Ready arriving in the last permitted cycle completes the fetch
    for (int i = 0; i < 14; i++) begin
      applyStimulus("last_wait", 8'h10, 1'b0, 1'b0, 1'b0, 1'b0, fetchE(1'b0));
    end
    applyStimulus("last_ok", 8'h10, 1'b1, 1'b0, 1'b0, 1'b0, fetchE(1'b1));
    applyStimulus("last_decode", 8'h10, 1'b1, 1'b0, 1'b0, 1'b0, idleE());
    e = idleE(); e.drv = 4'b0001; e.load = 4'b1000;
    applyStimulus("last_exec", 8'h10, 1'b1, 1'b0, 1'b0, 1'b0, e);

    // Reset in the middle of a stalled read
    applyStimulus("mid_fetch", 8'h24, 1'b1, 1'b0, 1'b0, 1'b0, fetchE(1'b1));
    applyStimulus("mid_decode", 8'h24, 1'b1, 1'b0, 1'b0, 1'b0, idleE());
    e = idleE(); e.rdMem = 1'b1; e.arOnAddr = 1'b1;
    applyStimulus("mid_wait", 8'h24, 1'b0, 1'b0, 1'b0, 1'b1, e);
    applyStimulus("mid_rst", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, idleE());
    applyStimulus("mid_refetch", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, fetchE(1'b1));
    applyStimulus("mid_decode2", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, idleE());
    applyStimulus("mid_exec2", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, idleE());

    // HLT sticks until reset
    runInstr("hlt", 8'hF0, 1'b0, 1'b0, idleE());
    e = idleE(); e.halted = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus("halted", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, e);
    end
    applyStimulus("halted_rst", 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, e);
    applyStimulus("halt_rst", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, idleE());
    applyStimulus("halt_refetch", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, fetchE(1'b1));

    @(negedge clk);
    #1;
    for (int i = 0; i < 20 && !done3; i++) begin
      @(negedge clk);
    end
    nChecks++;
    if (!done3) begin
      nFails++;
      $display("[TB] FAIL w3_done: got %0b expected 1", done3);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
